// File: rtl/l2s_monitor.sv
// rtl/l2s_monitor.sv - liveness-to-safety lasso monitor for FG p / GF p properties
// Optional loop-length counter and minimum-loop gate: define L2S_LOOP_LEN_EN.
module l2s_monitor #(
    parameter int STATE_W  = 8,
    parameter int NUM_FAIR = 1,
    parameter int MODE     = 0
`ifdef L2S_LOOP_LEN_EN
    ,
    parameter int MIN_LOOP = 1
`endif
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [STATE_W-1:0]  state_i,
    input  logic                p_i,
    input  logic [NUM_FAIR-1:0] fair_i,
    input  logic                loop_start_i,
    output logic                loop_started_o,
    output logic                loop_closed_o,
    output logic [STATE_W-1:0]  shadow_o,
    output logic                violation_now_o,
    output logic                violation_o
`ifdef L2S_LOOP_LEN_EN
    ,
    output logic [15:0]         loop_len_o
`endif
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_OPEN  = 2'd1,
        S_FIRED = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [STATE_W-1:0]    shadow_q, shadow_d;
    logic                  started_q, started_d;
    logic                  seen_bad_q, seen_bad_d;
    logic                  seen_good_q, seen_good_d;
    logic [NUM_FAIR-1:0]   fair_seen_q, fair_seen_d;
    logic                  violation_q, violation_d;
    logic                  len_ok;
    logic                  prop_refuted;
    logic                  closed;
    logic                  vnow;

`ifdef L2S_LOOP_LEN_EN
    logic [15:0]           len_q, len_d;

    assign len_ok     = (len_q >= 16'(MIN_LOOP));
    assign loop_len_o = len_q;
`else
    assign len_ok     = 1'b1;
`endif

    // Persistence is refuted by any low p in the loop; recurrence by p never high.
    assign prop_refuted = (MODE == 0) ? seen_bad_q : ~seen_good_q;

    // Flags are registered, so the closing cycle's own p/fair are excluded: they
    // duplicate the capture cycle's values because the states are equal.
    assign closed = started_q & (state_i == shadow_q) & len_ok;
    assign vnow   = closed & (&fair_seen_q) & prop_refuted;

    assign loop_started_o  = started_q;
    assign loop_closed_o   = closed;
    assign shadow_o        = shadow_q;
    assign violation_now_o = vnow;
    assign violation_o     = violation_q;

    // Next-state: capture in IDLE, accumulate in OPEN, freeze everything in FIRED.
    always_comb begin
        state_d     = state_q;
        shadow_d    = shadow_q;
        started_d   = started_q;
        seen_bad_d  = seen_bad_q;
        seen_good_d = seen_good_q;
        fair_seen_d = fair_seen_q;
        violation_d = violation_q;
`ifdef L2S_LOOP_LEN_EN
        len_d       = len_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (loop_start_i) begin
                    state_d     = S_OPEN;
                    shadow_d    = state_i;
                    started_d   = 1'b1;
                    seen_bad_d  = ~p_i;
                    seen_good_d = p_i;
                    fair_seen_d = fair_i;
`ifdef L2S_LOOP_LEN_EN
                    len_d       = 16'd0;
`endif
                end
            end
            S_OPEN: begin
                seen_bad_d  = seen_bad_q | ~p_i;
                seen_good_d = seen_good_q | p_i;
                fair_seen_d = fair_seen_q | fair_i;
`ifdef L2S_LOOP_LEN_EN
                if (len_q != 16'hFFFF) begin
                    len_d = len_q + 16'd1;
                end
`endif
                if (vnow) begin
                    state_d     = S_FIRED;
                    violation_d = 1'b1;
                end
            end
            S_FIRED: begin
                state_d = S_FIRED;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State register with synchronous active-low reset clearing every field.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            shadow_q    <= '0;
            started_q   <= 1'b0;
            seen_bad_q  <= 1'b0;
            seen_good_q <= 1'b0;
            fair_seen_q <= '0;
            violation_q <= 1'b0;
`ifdef L2S_LOOP_LEN_EN
            len_q       <= 16'd0;
`endif
        end else begin
            state_q     <= state_d;
            shadow_q    <= shadow_d;
            started_q   <= started_d;
            seen_bad_q  <= seen_bad_d;
            seen_good_q <= seen_good_d;
            fair_seen_q <= fair_seen_d;
            violation_q <= violation_d;
`ifdef L2S_LOOP_LEN_EN
            len_q       <= len_d;
`endif
        end
    end

endmodule

// File: doc/l2s_monitor.md
Name: l2s_monitor

Overview:
- Parametrised liveness-to-safety monitor for formal benches. It turns a persistence property (FG p) or a recurrence property (GF p) over a design-under-proof into a safety check.
- It nondeterministically snapshots a STATE_W-bit state vector on a free loop_start input. It then tracks the property and the fairness constraints inside the loop, and flags a violation when the state returns to the snapshot with a lasso that refutes the property.
- It is instantiated next to the DUT in the formal top. The prover drives loop_start_i freely; violation_o is asserted never-true.

Parameters:
- STATE_W, 8, width of the monitored state vector.
- NUM_FAIR, 1, number of fairness (justice) signals; each must be seen high at least once inside the loop for a lasso to count. Minimum 1; tie unused bits high.
- MODE, 0, 0 = persistence FG p (loop refutes it if p is low at least once in the loop); 1 = recurrence GF p (loop refutes it if p is never high in the loop).

Ports:
- clk  input  1  clock.
- rst  input  1  reset, synchronous, active-low.
- state_i  input  STATE_W  concatenated DUT state to compare.
- p_i  input  1  property predicate, sampled every cycle.
- fair_i  input  NUM_FAIR  fairness predicates.
- loop_start_i  input  1  free nondeterministic loop-start choice.
- loop_started_o  output  1  a snapshot is held.
- loop_closed_o  output  1  combinational: loop_started_o and state_i == shadow.
- shadow_o  output  STATE_W  captured state.
- violation_now_o  output  1  combinational lasso-violation condition this cycle.
- violation_o  output  1  sticky registered violation.

Behaviour:
- FSM states: IDLE, OPEN, FIRED, encoded in 2 bits. Reset (rst=0 at posedge) forces IDLE.
- Reset values on the same edge:
  - shadow = 0, seen_bad = 0, seen_good = 0, fair_seen = 0, violation_o = 0.
  - loop_started_o = 0.
- IDLE -> OPEN on a posedge with loop_start_i=1:
  - shadow <= state_i, loop_started_o <= 1.
  - Track flags load from the current cycle: seen_bad <= ~p_i, seen_good <= p_i, fair_seen <= fair_i.
- OPEN:
  - shadow frozen; loop_start_i ignored.
  - seen_bad |= ~p_i; seen_good |= p_i; fair_seen |= fair_i.
- loop_closed_o = loop_started_o & (state_i == shadow). It is valid from the first cycle after capture, so a 1-cycle self-loop counts.
- violation_now_o = loop_closed_o & (&fair_seen) & (MODE==0 ? seen_bad : ~seen_good).
  - Flags are registered, so the closing cycle's own p_i/fair_i are excluded. They are redundant with the capture cycle because the states are equal.
- OPEN -> FIRED when violation_now_o=1; violation_o <= 1 on that edge.
- FIRED: all registers hold; violation_o stays 1 until reset.
- A loop_closed_o without the violation conditions keeps OPEN with flags accumulating; a later closure may fire.
- Simultaneous rst=0 and loop_start_i=1: reset wins, IDLE.
- Reset mid-OPEN or mid-FIRED: everything is cleared on that edge.
- No arithmetic on state; the comparison is full-width equality.

Optional Feature:
- Macro L2S_LOOP_LEN_EN.
- Defined:
  - Adds parameter MIN_LOOP (default 1) and output loop_len_o of width 16.
  - The counter clears on capture, increments by 1 each OPEN cycle, and saturates at 16'hFFFF (no wrap).
  - loop_closed_o additionally requires loop_len_o >= MIN_LOOP.
  - Reset value of loop_len_o is 0; it holds in FIRED.
- Undefined: no counter, no loop_len_o port; closure as above.

Test Plan:
1. STATE_W=4, MODE=0, fair_i=1; state held at 4'h3, p_i=1, pulse loop_start_i at cycle 5 -> loop_closed_o=1 from cycle 6, violation_o stays 0 (p never low).
2. MODE=0; state sequence 1,2,3,1,2,3; loop_start_i at the first state 1, p_i=0 while state=2 -> violation_now_o=1 when state returns to 1, violation_o=1 the next cycle and sticky.
3. MODE=1; state cycling 5,6,5,6 with p_i=0 throughout, loop_start_i on state 5 -> violation at the return to 5. Repeat with p_i=1 on state 6 -> no violation.
4. NUM_FAIR=2, fair_i[1] held 0, MODE=0 with p_i low in the loop -> loop_closed_o pulses, violation_o stays 0. Raise fair_i[1] once inside the loop -> fires at the next closure.
5. In OPEN, drive rst=0 for one cycle with loop_start_i=1 -> loop_started_o=0, shadow=0, violation_o=0; a new capture occurs only on a later loop_start_i.
6. With L2S_LOOP_LEN_EN, MIN_LOOP=3, self-loop state 4'h7 and p_i=0 -> closure suppressed at loop_len_o=1,2; violation_o=1 after loop_len_o reaches 3.
